sm_result_fifo: RTL and testbench
=================================

SM_RESULT_FIFO -- requirements
Module: sm_result_fifo

Interface
REQ-001 Parameter: DW, 20, width of the stack-machine result word.
REQ-002 Parameter: DEPTH, 8, FIFO entries (power of two, >= 2).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 d_valid  in  1  stack-machine output strobe; one result per high cycle.
REQ-006 out_data  in  DW  stack-machine result, two's complement.
REQ-007 err_code  in  3  stack-machine status (0 = ok, nonzero = error/undefined/restore).
REQ-008 fin  in  1  stack-machine program-finished level.
REQ-009 o_valid  out  1  FIFO head entry available.
REQ-010 o_ready  in  1  consumer accepts head when o_valid & o_ready.
REQ-011 o_word  out  DW+3  head entry {err_code, out_data}.
REQ-012 level  out  log2(DEPTH)+1  current FIFO occupancy.
REQ-013 ok_cnt  out  8  accepted entries with err_code == 0, saturating.
REQ-014 err_cnt  out  8  accepted entries with err_code != 0, saturating.
REQ-015 overflow  out  1  sticky: at least one d_valid dropped because the FIFO was full.
REQ-016 done  out  1  program finished and FIFO fully drained.

Function
REQ-017 Control FSM states: RUN, DRAIN, DONE; RUN is entered on reset release.
REQ-018 An arm flag SHALL be set on the first d_valid accepted in RUN; fin SHALL be ignored while arm == 0, so the stack machine's spurious fin at pc == len == 0 is masked.
REQ-019 RUN -> DRAIN on posedge when fin == 1 and arm == 1; a d_valid in that same cycle SHALL still be captured.
REQ-020 DRAIN -> DONE on posedge when level == 0; DONE SHALL hold until reset.
REQ-021 In RUN, d_valid == 1 SHALL push {err_code, out_data} when level < DEPTH, or when level == DEPTH and a pop occurs in the same cycle.
REQ-022 In RUN, a d_valid with a full FIFO and no same-cycle pop SHALL be dropped, SHALL set overflow, and SHALL not change either counter.
REQ-023 In DRAIN and DONE, d_valid SHALL be ignored and SHALL change no state.
REQ-024 A pop SHALL occur when o_valid & o_ready; o_ready with an empty FIFO SHALL have no effect; there is no write-to-read bypass, so a word pushed in cycle N is first visible on o_word in cycle N+1.
REQ-025 o_valid SHALL equal (level != 0); o_word SHALL be the oldest entry and stable while o_valid & !o_ready.
REQ-026 A simultaneous push and pop SHALL leave level unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-027 ok_cnt / err_cnt SHALL increment by one per accepted push according to err_code and saturate at 255.
REQ-028 done SHALL be 1 exactly while the state is DONE.
REQ-029 Entries are stored verbatim; the block performs no arithmetic on data.

Reset
REQ-030 While rst_n == 0: state = RUN, arm = 0, pointers = 0, level = 0, o_valid = 0, o_word = 0, ok_cnt = 0, err_cnt = 0, overflow = 0, done = 0.
REQ-031 Reset asserted mid-operation SHALL discard FIFO contents immediately, without waiting for a clock edge.
REQ-032 Storage array contents need not be reset; o_word SHALL be forced to 0 while level == 0.

Structure
REQ-033 A shared package SHALL hold the FSM state encodings, the err_code values (OK = 0, ERR = 1, UND = 2, RESTORE = 4), and the default DW/DEPTH constants.
REQ-034 The FIFO SHALL be a sub-module named sm_fifo_core (storage, pointers, level, full/empty); the top level holds the FSM, arm flag, counters and overflow.

Verification
REQ-035 Reset, then d_valid for 3 cycles with data 5, 7, 12 and err 0, o_ready = 0 -> level = 3, ok_cnt = 3, o_word = {3'd0, 20'd5}.
REQ-036 Push 9 entries with o_ready = 0 -> level = 8, overflow = 1, ok_cnt = 8; after pops, o_word shows entries 1..8 in order.
REQ-037 Full FIFO with d_valid & o_ready in the same cycle -> level stays 8, no overflow, new word appears at the tail.
REQ-038 fin = 1 before any d_valid -> state stays RUN; then push one entry {1, 20'h0}, raise fin, drain -> err_cnt = 1; done rises the cycle after level reaches 0.
REQ-039 Drop rst_n mid-stream with level = 4 -> all outputs 0 asynchronously; after release, level = 0, state = RUN.
REQ-040 Push 300 ok entries with o_ready = 1 -> ok_cnt = 255 (saturated), level <= 1, overflow = 0.

Source files
------------

// File: rtl/sm_result_fifo_pkg.sv
// Shared definitions for the stack-machine result FIFO: FSM encodings,
// err_code values, default sizing and a saturating counter helper.
package sm_result_fifo_pkg;

  localparam int DW_DEF    = 20;
  localparam int DEPTH_DEF = 8;

  // Control FSM states, also visible on the debug state output.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Stack-machine status codes carried alongside each result word.
  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_ERR     = 3'd1;
  localparam logic [2:0] ERR_UND     = 3'd2;
  localparam logic [2:0] ERR_RESTORE = 3'd4;

  // Increment an 8-bit count, holding at 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sm_result_fifo_core.sv
// Synchronous FIFO storage: power-of-two depth, wrapping pointers, occupancy
// level, full/empty flags. The read port is masked to zero while empty.
module sm_fifo_core #(
  parameter int W     = 23,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [LW-1:0] LVL_ONE = 1;
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_MAX);
  // A push into a full FIFO is legal only when the head leaves the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // No bypass: the head comes from storage only, and reads as zero when empty.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage array; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; reset discards contents immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sm_result_fifo.sv
// Result collector for the stack machine: buffers {err_code, out_data} words,
// counts ok/error results, flags drops, and reports done once the program has
// finished and every buffered result has been consumed.
//
// Handshake: the head entry transfers on any cycle where o_valid && o_ready
// are both high at posedge clk; o_valid never depends on o_ready, and o_word
// holds steady while o_valid && !o_ready.
module sm_result_fifo
  import sm_result_fifo_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    d_valid,
  input  logic [DW-1:0]           out_data,
  input  logic [2:0]              err_code,
  input  logic                    fin,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [DW+2:0]           o_word,
  output logic [$clog2(DEPTH):0]  level,
  output logic [7:0]              ok_cnt,
  output logic [7:0]              err_cnt,
  output logic                    overflow,
  output logic                    done,
  output state_e                  dbg_state
);

  state_e state;
  logic   arm;
  logic   full;
  logic   empty;
  logic   pop;
  logic   in_run;
  logic   push_ok;
  logic   drop;

  assign o_valid   = !empty;
  assign pop       = o_valid && o_ready;
  assign in_run    = (state == ST_RUN);
  // Results are only taken while running; a full FIFO accepts if the head leaves.
  assign push_ok   = in_run && d_valid && (!full || pop);
  assign drop      = in_run && d_valid && full && !pop;
  assign dbg_state = state;

  sm_fifo_core #(
    .W     (DW + 3),
    .DEPTH (DEPTH)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .wdata ({err_code, out_data}),
    .pop   (pop),
    .rdata (o_word),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Control FSM with arm flag, result counters, sticky overflow and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      arm      <= 1'b0;
      ok_cnt   <= 8'd0;
      err_cnt  <= 8'd0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (push_ok) begin
            arm <= 1'b1;
            if (err_code == ERR_OK) ok_cnt  <= sat_inc(ok_cnt);
            else                    err_cnt <= sat_inc(err_cnt);
          end
          if (drop) overflow <= 1'b1;
          // fin before the first accepted result is the machine's idle artefact.
          if (fin && arm) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (level == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_result_fifo.sv
// Directed bench for sm_result_fifo: stimulus pushes expected head words into
// a queue; a monitor compares o_word against the queue head whenever o_valid.
module tb_sm_result_fifo;
  import sm_result_fifo_pkg::*;

  localparam int DW    = 20;
  localparam int DEPTH = 8;

  logic            clk;
  logic            rst_n;
  logic            d_valid;
  logic [DW-1:0]   out_data;
  logic [2:0]      err_code;
  logic            fin;
  logic            o_valid;
  logic            o_ready;
  logic [DW+2:0]   o_word;
  logic [3:0]      level;
  logic [7:0]      ok_cnt;
  logic [7:0]      err_cnt;
  logic            overflow;
  logic            done;
  state_e          dbg_state;

  logic [DW+2:0]   exp_q[$];
  int              n_vec;
  int              n_bad;

  sm_result_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_valid   (d_valid),
    .out_data  (out_data),
    .err_code  (err_code),
    .fin       (fin),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_word    (o_word),
    .level     (level),
    .ok_cnt    (ok_cnt),
    .err_cnt   (err_cnt),
    .overflow  (overflow),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    d_valid  = 1'b0;
    out_data = '0;
    err_code = 3'd0;
    fin      = 1'b0;
    o_ready  = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Driver: one d_valid cycle; acc says whether the word must be accepted.
  task automatic push_word(input logic [DW-1:0] data, input logic [2:0] err, input bit acc);
    d_valid  = 1'b1;
    out_data = data;
    err_code = err;
    if (acc) exp_q.push_back({err, data});
    step();
    d_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Scoreboard monitor: head must match the oldest expected word; pop on transfer.
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL head: o_word %0h presented, expected queue empty at %0t", o_word, $time);
      end else begin
        check("head", 32'(o_word), 32'(exp_q[0]));
        if (o_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    n_vec = 0;
    n_bad = 0;

    // Reset values
    do_reset();
    check("rst_level", 32'(level), 0);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_word", 32'(o_word), 0);
    check("rst_ok", 32'(ok_cnt), 0);
    check("rst_err", 32'(err_cnt), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_done", 32'(done), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_RUN));

    // Three ok results held back
    push_word(20'd5, 3'd0, 1);
    push_word(20'd7, 3'd0, 1);
    push_word(20'd12, 3'd0, 1);
    idle(1);
    check("three_level", 32'(level), 3);
    check("three_ok", 32'(ok_cnt), 3);
    check("three_word", 32'(o_word), 32'h5);
    o_ready = 1'b1;
    idle(4);
    o_ready = 1'b0;
    check("three_drained", 32'(level), 0);
    check("empty_word", 32'(o_word), 0);

    // Full FIFO with a same-cycle push and pop
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(20'(i), 3'd0, 1);
    check("full_level", 32'(level), 8);
    o_ready = 1'b1;
    push_word(20'd100, 3'd0, 1);
    o_ready = 1'b0;
    check("pp_level", 32'(level), 8);
    check("pp_ovf", 32'(overflow), 0);
    check("pp_ok", 32'(ok_cnt), 9);
    o_ready = 1'b1;
    idle(10);
    o_ready = 1'b0;
    check("pp_drained", 32'(level), 0);

    // Overflow: ninth push dropped
    do_reset();
    for (int i = 1; i <= 9; i++) push_word(20'(i), 3'd0, i <= 8);
    check("ovf_level", 32'(level), 8);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_ok", 32'(ok_cnt), 8);
    o_ready = 1'b1;
    idle(10);
    o_ready = 1'b0;
    check("ovf_drained", 32'(level), 0);
    check("ovf_sticky", 32'(overflow), 1);

    // Early fin masked, then drain to done
    do_reset();
    fin = 1'b1;
    idle(3);
    check("fin_masked", 32'(dbg_state), 32'(ST_RUN));
    check("fin_nodone", 32'(done), 0);
    push_word(20'h0, ERR_ERR, 1);
    idle(1);
    check("drain_state", 32'(dbg_state), 32'(ST_DRAIN));
    check("drain_level", 32'(level), 1);
    check("drain_err", 32'(err_cnt), 1);
    push_word(20'h3, 3'd0, 0);
    check("drain_ignore", 32'(level), 1);
    o_ready = 1'b1;
    idle(1);
    check("drain_empty", 32'(level), 0);
    check("drain_notdone", 32'(done), 0);
    idle(1);
    check("done_rise", 32'(done), 1);
    check("done_state", 32'(dbg_state), 32'(ST_DONE));
    push_word(20'h9, 3'd0, 0);
    check("done_ignore_lvl", 32'(level), 0);
    check("done_ignore_ok", 32'(ok_cnt), 0);
    check("done_hold", 32'(done), 1);
    o_ready = 1'b0;
    fin = 1'b0;

    // Asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 4; i++) push_word(20'(i + 40), 3'd0, 1);
    check("mid_level", 32'(level), 4);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_level", 32'(level), 0);
    check("async_valid", 32'(o_valid), 0);
    check("async_word", 32'(o_word), 0);
    check("async_ok", 32'(ok_cnt), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("post_level", 32'(level), 0);
    check("post_state", 32'(dbg_state), 32'(ST_RUN));

    // Counter saturation with a streaming consumer
    do_reset();
    o_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      push_word(20'(i), 3'd0, 1);
      if (i == 150) check("stream_level_le1", 32'(level <= 4'd1), 1);
    end
    idle(2);
    o_ready = 1'b0;
    check("sat_ok", 32'(ok_cnt), 255);
    check("sat_ovf", 32'(overflow), 0);
    check("sat_level", 32'(level), 0);

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
